register_file_mp: RTL and testbench
===================================

# register_file_mp

Multi-port successor to the two-read/one-write register file. It keeps the MIPS `$zero` convention and adds:
- parametrised read and write port counts;
- optional same-cycle write-to-read bypass;
- asynchronous clear of all registers;
- a per-register busy scoreboard that the pipeline uses to reserve destination registers at issue and release them at writeback.

It sits between decode/issue, which reads operands and reserves destinations, and the writeback stages, which write results, one port per retiring unit.

## Interface
- `COUNT`, 32, number of registers; address width `ADDR_WIDTH = $clog2(COUNT)`.
- `BUS_WIDTH`, 32, data width.
- `READ_PORTS`, 2, number of read ports, 1..8.
- `WRITE_PORTS`, 2, number of write ports, 1..4.
- `BYPASS`, 1, 1 = same-cycle write data forwarded to reads; 0 = reads return pre-write contents.

- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `read_addr`  in  `READ_PORTS*ADDR_WIDTH`  packed read addresses; port k occupies bits `[k*ADDR_WIDTH +: ADDR_WIDTH]`.
- `data_out`  out  `READ_PORTS*BUS_WIDTH`  packed read data, combinational.
- `read_busy`  out  `READ_PORTS`  scoreboard bit of each read address, combinational.
- `write_addr`  in  `WRITE_PORTS*ADDR_WIDTH`  packed write addresses.
- `data_in`  in  `WRITE_PORTS*BUS_WIDTH`  packed write data.
- `wr_en`  in  `WRITE_PORTS`  per-port write enable.
- `reserve_en`  in  1  request to mark `reserve_addr` busy.
- `reserve_addr`  in  `ADDR_WIDTH`  destination register to reserve.
- `reserve_ack`  out  1  combinational grant: `reserve_en & (reserve_addr != 0) & ~busy[reserve_addr]`.
- `busy_vec`  out  `COUNT`  registered scoreboard; bit 0 is constant 0.

## Operation
- **Register 0**
  - Reads return 0.
  - Writes are discarded.
  - Reservations are never granted.
  - `busy_vec[0]` is tied to 0.
- **Reset**
  - `rst_n` low clears registers 1..COUNT-1 to 0 and `busy_vec` to 0 immediately, independent of `clk`.
  - While `rst_n` is low, writes and reservations are ignored.
  - Combinational outputs still track inputs: `data_out` reads 0, plus bypass data when `BYPASS=1`.
- **Writes**
  - On each rising edge, every port with `wr_en[j]=1` and a non-zero address updates its register.
  - If two or more enabled ports target the same address, the highest-index port wins.
- **Reads**
  - `data_out[k]` = stored value of `read_addr[k]`.
  - With `BYPASS=1`, if any enabled write targets `read_addr[k]` (non-zero) in the same cycle, `data_out[k]` is the winning write data instead.
- **Scoreboard**
  - `busy_next[r] = (busy[r] & ~written[r]) | granted[r]`.
  - `written[r]` = any enabled write to r this cycle; `granted[r]` = `reserve_ack` with `reserve_addr == r`.
  - Effect: a grant outranks a same-cycle write release of the same register.
  - A write to a register that is not busy is legal and leaves it not busy.
  - A reserve request to an already-busy register is refused (`reserve_ack=0`) with no state change; the requester retries.
- **`read_busy[k]`**
  - `BYPASS=0`: `read_busy[k] = busy[read_addr[k]]`.
  - `BYPASS=1`: `read_busy[k] = busy[read_addr[k]] & ~written[read_addr[k]]`, because the value is being forwarded this cycle.

## Timing
- Read latency: 0 cycles (combinational from `read_addr`, or from write inputs when `BYPASS=1`).
- Write latency: data becomes visible in storage after the rising edge; with `BYPASS=1` it is also visible in the same cycle.
- Reserve:
  - `reserve_ack` is valid in the same cycle as the request.
  - `busy_vec` bit rises 1 cycle later.
  - The release write clears the bit at the edge on which that write occurs.
- Reset values: `busy_vec=0`, `reserve_ack=0` unless requested, `data_out=0`, `read_busy=0`.
- Reset released mid-reservation: all reservations are lost. Issue logic is reset by the same `rst_n`.

## Test plan
- **Reset:** write 0xDEADBEEF to r5, reserve r7, assert `rst_n=0` mid-cycle -> r5 reads 0 and `busy_vec=0` immediately, before the next edge.
- **Write conflict:** ports 0 and 1 both write r3 with 0x11 and 0x22 -> r3=0x22. Write r0=0xFF -> r0 reads 0 and `busy_vec[0]=0`.
- **Bypass:** r4=0xA; same cycle write r4=0xB while reading r4.
  - `BYPASS=1` -> `data_out=0xB` that cycle.
  - `BYPASS=0` -> `data_out=0xA` that cycle, 0xB the next.
- **Reserve/release:**
  - Reserve r9 -> `reserve_ack=1`, then `busy_vec[9]=1`.
  - Reserve r9 again -> `reserve_ack=0`.
  - Write r9=0x55 -> `busy_vec[9]=0` next cycle and r9=0x55.
- **Simultaneous events:**
  - r6 busy: write r6 and request reserve r6 in one cycle -> ack=0, bit clears.
  - r6 not busy: same stimulus -> ack=1, bit set, r6 holds the written data.
- **Parameter sweep:** `COUNT=16`, `BUS_WIDTH=8`, `READ_PORTS=4`, `WRITE_PORTS=1` -> random write/read/reserve traffic matches the reference model on every cycle.

Source files
------------

// File: rtl/register_file_mp.sv
// Multi-port register file with MIPS-style hard-wired zero register,
// optional same-cycle write-to-read forwarding and a per-register busy
// scoreboard used by issue (reserve) and writeback (release).
module register_file_mp #(
  parameter int COUNT       = 32,
  parameter int BUS_WIDTH   = 32,
  parameter int READ_PORTS  = 2,
  parameter int WRITE_PORTS = 2,
  parameter int BYPASS      = 1,
  parameter int ADDR_WIDTH  = $clog2(COUNT)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [READ_PORTS*ADDR_WIDTH-1:0]  read_addr,
  output logic [READ_PORTS*BUS_WIDTH-1:0]   data_out,
  output logic [READ_PORTS-1:0]             read_busy,
  input  logic [WRITE_PORTS*ADDR_WIDTH-1:0] write_addr,
  input  logic [WRITE_PORTS*BUS_WIDTH-1:0]  data_in,
  input  logic [WRITE_PORTS-1:0]            wr_en,
  input  logic                              reserve_en,
  input  logic [ADDR_WIDTH-1:0]             reserve_addr,
  output logic                              reserve_ack,
  output logic [COUNT-1:0]                  busy_vec
);

  // Bit 0 of the scoreboard can never be set.
  localparam logic [COUNT-1:0] NONZERO_MASK = {{(COUNT-1){1'b1}}, 1'b0};

  logic [BUS_WIDTH-1:0] mem     [COUNT];
  logic [BUS_WIDTH-1:0] wr_data [COUNT];
  logic [COUNT-1:0]     written;
  logic [COUNT-1:0]     granted;
  logic [COUNT-1:0]     busy;

  // Resolve write ports per register; later ports overwrite earlier ones so the
  // highest-index enabled port wins. Writes to register 0 are dropped here.
  always_comb begin
    written = '0;
    for (int r = 0; r < COUNT; r++) wr_data[r] = '0;
    for (int j = 0; j < WRITE_PORTS; j++) begin
      if (wr_en[j] && (write_addr[j*ADDR_WIDTH +: ADDR_WIDTH] != '0)) begin
        written[write_addr[j*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b1;
        wr_data[write_addr[j*ADDR_WIDTH +: ADDR_WIDTH]] = data_in[j*BUS_WIDTH +: BUS_WIDTH];
      end
    end
  end

  // Storage; register 0 is held at zero by never being written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < COUNT; r++) mem[r] <= '0;
    end else begin
      for (int r = 1; r < COUNT; r++) begin
        if (written[r]) mem[r] <= wr_data[r];
      end
    end
  end

  assign reserve_ack = reserve_en && (reserve_addr != '0) && !busy[reserve_addr];

  // One-hot of the register granted this cycle.
  always_comb begin
    granted = '0;
    granted[reserve_addr] = reserve_ack;
  end

  // Scoreboard: a write releases, a grant reserves; a grant outranks a release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      busy <= ((busy & ~written) | granted) & NONZERO_MASK;
    end
  end

  assign busy_vec = busy;

  // Read ports; with forwarding enabled a same-cycle write replaces the stored
  // value and also hides the busy bit, since the result is already here.
  always_comb begin
    data_out  = '0;
    read_busy = '0;
    for (int k = 0; k < READ_PORTS; k++) begin
      if ((BYPASS != 0) && written[read_addr[k*ADDR_WIDTH +: ADDR_WIDTH]]) begin
        data_out[k*BUS_WIDTH +: BUS_WIDTH] = wr_data[read_addr[k*ADDR_WIDTH +: ADDR_WIDTH]];
        read_busy[k] = 1'b0;
      end else begin
        data_out[k*BUS_WIDTH +: BUS_WIDTH] = mem[read_addr[k*ADDR_WIDTH +: ADDR_WIDTH]];
        read_busy[k] = busy[read_addr[k*ADDR_WIDTH +: ADDR_WIDTH]];
      end
    end
  end

endmodule

// File: tb/tb_register_file_mp.sv
// Bench for register_file_mp: a default-parameter instance (forwarding on)
// and a narrow instance (16 x 8 bit, 4 read / 1 write, forwarding off),
// both checked every cycle against an array-based reference model.
module tb_register_file_mp;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Instance A: COUNT=32, BUS_WIDTH=32, READ_PORTS=2, WRITE_PORTS=2, BYPASS=1
  logic [9:0]  a_ra;
  logic [63:0] a_dout;
  logic [1:0]  a_rbusy;
  logic [9:0]  a_wa;
  logic [63:0] a_din;
  logic [1:0]  a_we;
  logic        a_res_en;
  logic [4:0]  a_res_addr;
  logic        a_ack;
  logic [31:0] a_busy;

  // Instance B: COUNT=16, BUS_WIDTH=8, READ_PORTS=4, WRITE_PORTS=1, BYPASS=0
  logic [15:0] b_ra;
  logic [31:0] b_dout;
  logic [3:0]  b_rbusy;
  logic [3:0]  b_wa;
  logic [7:0]  b_din;
  logic [0:0]  b_we;
  logic        b_res_en;
  logic [3:0]  b_res_addr;
  logic        b_ack;
  logic [15:0] b_busy;

  register_file_mp dut_a (
    .clk(clk), .rst_n(rst_n),
    .read_addr(a_ra), .data_out(a_dout), .read_busy(a_rbusy),
    .write_addr(a_wa), .data_in(a_din), .wr_en(a_we),
    .reserve_en(a_res_en), .reserve_addr(a_res_addr),
    .reserve_ack(a_ack), .busy_vec(a_busy)
  );

  register_file_mp #(
    .COUNT(16), .BUS_WIDTH(8), .READ_PORTS(4), .WRITE_PORTS(1), .BYPASS(0)
  ) dut_b (
    .clk(clk), .rst_n(rst_n),
    .read_addr(b_ra), .data_out(b_dout), .read_busy(b_rbusy),
    .write_addr(b_wa), .data_in(b_din), .wr_en(b_we),
    .reserve_en(b_res_en), .reserve_addr(b_res_addr),
    .reserve_ack(b_ack), .busy_vec(b_busy)
  );

  // Reference model state
  logic [31:0] ma_reg [32];
  bit          ma_busy[32];
  logic [7:0]  mb_reg [16];
  bit          mb_busy[16];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int r = 0; r < 32; r++) begin ma_reg[r] = '0; ma_busy[r] = 0; end
    for (int r = 0; r < 16; r++) begin mb_reg[r] = '0; mb_busy[r] = 0; end
  endtask

  task automatic idle();
    a_ra = '0; a_wa = '0; a_din = '0; a_we = '0; a_res_en = 0; a_res_addr = '0;
    b_ra = '0; b_wa = '0; b_din = '0; b_we = '0; b_res_en = 0; b_res_addr = '0;
  endtask

  // Called just after a rising edge with inputs already driven: checks all
  // combinational/registered outputs of both instances, then advances the model.
  task automatic step();
    logic [31:0] awv[32];
    bit          awr[32];
    logic [7:0]  bwv[16];
    bit          bwr[16];
    logic [31:0] exp_a, abv;
    logic [7:0]  exp_b;
    logic [15:0] bbv;
    bit          aack, back;
    int          ad;
    for (int r = 0; r < 32; r++) begin awr[r] = 0; awv[r] = '0; end
    for (int r = 0; r < 16; r++) begin bwr[r] = 0; bwv[r] = '0; end
    // ports applied in index order: last enabled one to an address wins
    for (int j = 0; j < 2; j++) begin
      ad = int'(a_wa[j*5 +: 5]);
      if (a_we[j] && ad != 0) begin awr[ad] = 1; awv[ad] = a_din[j*32 +: 32]; end
    end
    ad = int'(b_wa);
    if (b_we[0] && ad != 0) begin bwr[ad] = 1; bwv[ad] = b_din; end
    #2;
    for (int k = 0; k < 2; k++) begin
      ad = int'(a_ra[k*5 +: 5]);
      if (ad == 0)       exp_a = 32'h0;
      else if (awr[ad])  exp_a = awv[ad];
      else               exp_a = ma_reg[ad];
      chk($sformatf("a_data_out[%0d] r%0d", k, ad), 64'(a_dout[k*32 +: 32]), 64'(exp_a));
      chk($sformatf("a_read_busy[%0d] r%0d", k, ad), 64'(a_rbusy[k]), 64'(ma_busy[ad] && !awr[ad]));
    end
    for (int k = 0; k < 4; k++) begin
      ad = int'(b_ra[k*4 +: 4]);
      exp_b = (ad == 0) ? 8'h0 : mb_reg[ad];
      chk($sformatf("b_data_out[%0d] r%0d", k, ad), 64'(b_dout[k*8 +: 8]), 64'(exp_b));
      chk($sformatf("b_read_busy[%0d] r%0d", k, ad), 64'(b_rbusy[k]), 64'(mb_busy[ad]));
    end
    aack = a_res_en && a_res_addr != 0 && !ma_busy[a_res_addr];
    back = b_res_en && b_res_addr != 0 && !mb_busy[b_res_addr];
    chk("a_reserve_ack", 64'(a_ack), 64'(aack));
    chk("b_reserve_ack", 64'(b_ack), 64'(back));
    for (int r = 0; r < 32; r++) abv[r] = ma_busy[r];
    for (int r = 0; r < 16; r++) bbv[r] = mb_busy[r];
    chk("a_busy_vec", 64'(a_busy), 64'(abv));
    chk("b_busy_vec", 64'(b_busy), 64'(bbv));
    @(posedge clk);
    if (rst_n) begin
      for (int r = 1; r < 32; r++) begin
        if (awr[r]) ma_reg[r] = awv[r];
        ma_busy[r] = (ma_busy[r] && !awr[r]) || (aack && int'(a_res_addr) == r);
      end
      for (int r = 1; r < 16; r++) begin
        if (bwr[r]) mb_reg[r] = bwv[r];
        mb_busy[r] = (mb_busy[r] && !bwr[r]) || (back && int'(b_res_addr) == r);
      end
    end
    #1;
  endtask

  initial begin
    int hi;
    rst_n = 1'b0;
    model_clear();
    idle();
    // reset state
    a_ra = {5'd5, 5'd0};
    b_ra = {4'd3, 4'd2, 4'd1, 4'd0};
    step();
    rst_n = 1'b1;

    // write r5, reserve r7, then read both back
    a_wa[4:0] = 5'd5; a_din[31:0] = 32'hDEADBEEF; a_we = 2'b01;
    a_res_en = 1; a_res_addr = 5'd7;
    b_wa = 4'd5; b_din = 8'hC3; b_we = 1'b1; b_res_en = 1; b_res_addr = 4'd7;
    step();
    idle();
    a_ra = {5'd7, 5'd5};
    b_ra = {4'd0, 4'd0, 4'd7, 4'd5};
    step();

    // asynchronous reset mid-cycle: effect visible before the next edge
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset_async_r5", 64'(a_dout[31:0]), 64'h0);
    chk("reset_async_busy", 64'(a_busy), 64'h0);
    chk("reset_async_b_r5", 64'(b_dout[7:0]), 64'h0);
    model_clear();
    @(posedge clk); #1;
    // writes and reservations during reset are ignored (A still forwards)
    a_wa = {5'd5, 5'd0}; a_din = {32'h1234_5678, 32'h0}; a_we = 2'b10;
    a_res_en = 1; a_res_addr = 5'd8;
    a_ra = {5'd8, 5'd5};
    b_wa = 4'd5; b_din = 8'h77; b_we = 1'b1; b_ra = {12'h0, 4'd5};
    step();
    rst_n = 1'b1;
    idle();
    a_ra = {5'd8, 5'd5};
    b_ra = {12'h0, 4'd5};
    step();

    // write conflict: port 1 wins
    a_wa = {5'd3, 5'd3}; a_din = {32'h22, 32'h11}; a_we = 2'b11;
    step();
    idle();
    a_ra = {5'd0, 5'd3};
    step();
    chk("conflict_r3", 64'(a_dout[31:0]), 64'h22);
    // write to r0 is discarded
    a_wa = {5'd0, 5'd0}; a_din = {32'hFF, 32'hFF}; a_we = 2'b11;
    a_ra = {5'd0, 5'd0};
    b_wa = 4'd0; b_din = 8'hFF; b_we = 1'b1; b_ra = '0;
    step();
    idle();
    step();

    // bypass: A forwards, B returns the old value until the edge
    a_wa[4:0] = 5'd4; a_din[31:0] = 32'hA; a_we = 2'b01;
    b_wa = 4'd4; b_din = 8'hA; b_we = 1'b1;
    step();
    a_din[31:0] = 32'hB; a_ra = {5'd4, 5'd4};
    b_din = 8'hB; b_ra = {4'd4, 4'd4, 4'd4, 4'd4};
    step();
    idle();
    a_ra = {5'd4, 5'd4};
    b_ra = {4'd4, 4'd4, 4'd4, 4'd4};
    step();

    // reserve / refuse / release of r9
    a_res_en = 1; a_res_addr = 5'd9; a_ra = {5'd9, 5'd9};
    b_res_en = 1; b_res_addr = 4'd9; b_ra = {4'd9, 4'd9, 4'd9, 4'd9};
    step();
    step();
    idle();
    a_wa[4:0] = 5'd9; a_din[31:0] = 32'h55; a_we = 2'b01; a_ra = {5'd9, 5'd9};
    b_wa = 4'd9; b_din = 8'h55; b_we = 1'b1; b_ra = {4'd9, 4'd9, 4'd9, 4'd9};
    step();
    idle();
    a_ra = {5'd9, 5'd9};
    b_ra = {4'd9, 4'd9, 4'd9, 4'd9};
    step();

    // simultaneous write + reserve on r6: busy then not busy
    a_res_en = 1; a_res_addr = 5'd6; b_res_en = 1; b_res_addr = 4'd6;
    step();
    a_wa = {5'd6, 5'd0}; a_din = {32'h66, 32'h0}; a_we = 2'b10;
    b_wa = 4'd6; b_din = 8'h66; b_we = 1'b1;
    a_ra = {5'd6, 5'd0}; b_ra = {12'h0, 4'd6};
    step();
    a_din = {32'h67, 32'h0}; b_din = 8'h67;
    step();
    idle();
    a_ra = {5'd6, 5'd0}; b_ra = {12'h0, 4'd6};
    step();

    // random traffic on both instances
    for (int i = 0; i < 400; i++) begin
      hi = (i % 3 == 0) ? 31 : 9;
      for (int k = 0; k < 2; k++) a_ra[k*5 +: 5] = 5'($urandom_range(0, hi));
      for (int j = 0; j < 2; j++) begin
        a_wa[j*5 +: 5]   = 5'($urandom_range(0, hi));
        a_din[j*32 +: 32] = $urandom;
        a_we[j]          = 1'($urandom_range(0, 1));
      end
      a_res_en   = 1'($urandom_range(0, 1));
      a_res_addr = 5'($urandom_range(0, hi));
      hi = (i % 3 == 0) ? 15 : 7;
      for (int k = 0; k < 4; k++) b_ra[k*4 +: 4] = 4'($urandom_range(0, hi));
      b_wa     = 4'($urandom_range(0, hi));
      b_din    = 8'($urandom);
      b_we     = 1'($urandom_range(0, 1));
      b_res_en = 1'($urandom_range(0, 1));
      b_res_addr = 4'($urandom_range(0, hi));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
